// File: rtl/mole_sequencer.sv
// Whack-a-mole round sequencer: reads a target pattern, lights one mole
// at a time, and tallies hits and timeouts.
module mole_sequencer #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int LAST_ADDR   = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [5:0] hit_i,
  output logic [3:0] rd_address_o,
  input  logic [3:0] rd_data_i,
  output logic [5:0] mole_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] score_o,
  output logic [4:0] misses_o
);

  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SHOW_END = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] RD_END   = CW'(1);
  localparam logic [3:0]    LAST     = 4'(LAST_ADDR);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] SHOW = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          arm_q, arm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [5:0]    mole_q, mole_d;
  logic [5:0]    hit_q;
  logic [4:0]    score_q, score_d;
  logic [4:0]    miss_q, miss_d;
  logic          busy_q, done_q;
  logic [5:0]    rise;
  logic          match;
  logic          adv;

  assign rise  = hit_i & ~hit_q;
  assign match = |(rise & mole_q);

  always_comb begin
    state_d = state_q;
    arm_d   = 1'b0;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mole_d  = mole_q;
    score_d = score_q;
    miss_d  = miss_q;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // start is captured one cycle ahead so the address settles first
        if (arm_q) begin
          state_d = READ;
          cnt_d   = '0;
        end else if (start_i) begin
          arm_d   = 1'b1;
          score_d = '0;
          miss_d  = '0;
          addr_d  = '0;
        end
      end
      READ: begin
        if (cnt_q == RD_END) begin
          if (rd_data_i <= 4'd5) begin
            mole_d  = 6'b000001 << rd_data_i[2:0];
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (match) begin
          score_d = (score_q == 5'd31) ? score_q : score_q + 5'd1;
          mole_d  = '0;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == SHOW_END) begin
          miss_d  = (miss_q == 5'd31) ? miss_q : miss_q + 5'd1;
          mole_d  = '0;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_END) adv = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      cnt_d = '0;
      if (addr_q == LAST) begin
        state_d = DONE;
      end else begin
        addr_d  = addr_q + 4'd1;
        state_d = READ;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      mole_q  <= '0;
      hit_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mole_q  <= mole_d;
      hit_q   <= hit_i;
      score_q <= score_d;
      miss_q  <= miss_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign rd_address_o = addr_q;
  assign mole_o       = mole_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign score_o      = score_q;
  assign misses_o     = miss_q;

endmodule

// File: doc/mole_sequencer.md
MOLE_SEQUENCER -- requirements
Module: mole_sequencer

Interface
REQ-001 Parameter SHOW_CYCLES, default 50000000, clock cycles a mole stays lit with no hit.
REQ-002 Parameter GAP_CYCLES, default 12500000, clock cycles with all moles dark between targets.
REQ-003 Parameter LAST_ADDR, default 15, final pattern-memory address read in a round (0..15).
REQ-004 clock  in  1  single system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a round; sampled only in IDLE.
REQ-007 hit  in  6  whack buttons, one bit per engineer; active-high, already debounced, synchronous to clock.
REQ-008 rd_address  out  4  read address to the pattern memory written by the random generator.
REQ-009 rd_data  in  4  pattern-memory output; valid values 0..5.
REQ-010 mole  out  6  one-hot lit engineer, all-zero when none.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at end of round.
REQ-013 score  out  5  targets hit this round.
REQ-014 misses  out  5  targets timed out this round.

Function
REQ-015 States SHALL be IDLE, READ, SHOW, GAP, DONE; all outputs registered.
REQ-016 IDLE + start=1 -> clear score and misses, rd_address<=0, enter READ.
REQ-017 READ SHALL last exactly 2 cycles (covers registered-address memory latency), with rd_address held stable throughout.
REQ-018 On the final READ edge: rd_data<=5 -> mole<=one-hot(rd_data), SHOW counter cleared, enter SHOW; rd_data>=6 -> mole stays zero, no counter change, go directly to next-address logic (REQ-022).
REQ-019 mole SHALL become valid on the 3rd rising edge after the edge that samples start.
REQ-020 Hit detection: rising edge of hit[i], computed against a registered copy of hit updated every cycle; a button already held when the mole lights SHALL NOT score.
REQ-021 In SHOW: edge on hit bit matching mole -> score+1, mole<=0, enter GAP on the same edge; edges on other bits ignored; counter reaching SHOW_CYCLES with no matching edge -> misses+1, mole<=0, enter GAP.
REQ-022 In GAP, after GAP_CYCLES cycles: rd_address==LAST_ADDR -> enter DONE; otherwise rd_address+1, enter READ.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; score and misses held until next start.
REQ-024 Matching hit and SHOW timeout on the same edge -> hit wins (score+1, misses unchanged).
REQ-025 Matching and non-matching edges on the same edge -> counts as hit.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 score and misses SHALL saturate at 31; rd_address never exceeds LAST_ADDR.
REQ-028 Counters SHALL be wide enough for max(SHOW_CYCLES, GAP_CYCLES) with no wrap.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, rd_address=0, mole=0, busy=0, done=0, score=0, misses=0, hit history=0, counters=0, regardless of state.
REQ-030 After reset deasserts mid-round, the block SHALL stay in IDLE until a new start; the interrupted round is not resumed.

Verification (SHOW_CYCLES=8, GAP_CYCLES=2, LAST_ADDR=3, memory {2,5,7,0})
REQ-031 start pulse, no hits -> mole 000100, then 100000, (addr 2 skipped, no mole), then 000001; each lit 8 cycles; done pulse; score=0, misses=3.
REQ-032 hit[2] rising 3 cycles into first SHOW -> mole clears that edge; score=1; GAP 2 cycles; rd_address advances to 1.
REQ-033 hit[2] held high before mole 000100 lights and never released -> no score; misses increments at timeout.
REQ-034 hit[5] rising on the exact timeout edge of mole 100000 -> score+1, misses unchanged.
REQ-035 reset low during second SHOW -> all outputs zero at once; start ignored while busy; fresh start after release replays from address 0 with score=0.
REQ-036 hit[0] and hit[3] rising together while mole=000001 -> score+1.
